// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit with private HI/LO registers for the MIPS pipeline.
// One shift-add or restoring-divide step per cycle, then a single sign fix-up cycle.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             HiWe,
  input  logic             LoWe,
  input  logic [WIDTH-1:0] WData,
  input  logic             ReadReq,
  input  logic             Abort,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic             DivZero
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opm_q, opm_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             divzero_q, divzero_d;

  // Operand decode at issue
  logic             a_neg, b_neg, op_is_div, op_dz;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign op_is_div = Op[1];
  assign a_neg     = !Op[0] && OpA[WIDTH-1];
  assign b_neg     = !Op[0] && OpB[WIDTH-1];
  assign a_mag     = a_neg ? (-OpA) : OpA;
  assign b_mag     = b_neg ? (-OpB) : OpB;
  assign op_dz     = op_is_div && (OpB == '0);

  // One iteration of each datapath
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ok;

  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opm_q} : '0);
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opm_q};
  assign div_ok    = !div_diff[WIDTH];

  // Sign fix-up of the finished result
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_raw = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_q ? (-prod_raw) : prod_raw;
  assign quo_fix  = neg_q ? (-acc_lo_q) : acc_lo_q;
  assign rem_fix  = rem_neg_q ? (-acc_hi_q) : acc_hi_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dz_d      = dz_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opm_d     = opm_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Abort) begin
          state_d = IDLE;
        end else if (Start) begin
          state_d   = RUN;
          busy_d    = 1'b1;
          cnt_d     = '0;
          is_div_d  = op_is_div;
          dz_d      = op_dz;
          neg_d     = !op_dz && (a_neg ^ b_neg);
          rem_neg_d = !op_dz && a_neg;
          acc_hi_d  = '0;
          // A zero divisor divides the raw dividend: remainder ends as OpA, quotient as all ones.
          acc_lo_d  = op_is_div ? (op_dz ? OpA : a_mag) : b_mag;
          opm_d     = op_is_div ? b_mag : a_mag;
        end else begin
          if (HiWe) hi_d = WData;
          if (LoWe) lo_d = WData;
        end
      end

      RUN: begin
        if (Abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (is_div_q) begin
            acc_hi_d = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ok};
          end else begin
            acc_hi_d = mul_sum[WIDTH:1];
            acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
          end
          if (cnt_q == LAST_ITER) state_d = FIX;
        end
      end

      FIX: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
        if (!Abort) begin
          done_d    = 1'b1;
          divzero_d = dz_q;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opm_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dz_q      <= dz_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opm_q     <= opm_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign Hi      = hi_q;
  assign Lo      = lo_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = divzero_q;
  // Hazard request is combinational so it freezes the same cycle the EX conflict appears
  assign Stall   = busy_q && (Start || ReadReq || HiWe || LoWe);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, latency, stall, abort and reset.
module tb_muldiv_sequencer;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] OpA, OpB;
  logic        HiWe, LoWe;
  logic [31:0] WData;
  logic        ReadReq, Abort;
  logic [31:0] Hi, Lo;
  logic        Busy, Stall, Done, DivZero;

  int total = 0;
  int bad   = 0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
    .HiWe(HiWe), .LoWe(LoWe), .WData(WData), .ReadReq(ReadReq), .Abort(Abort),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Stall(Stall), .Done(Done), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!reset) assert (!(Start && (HiWe || LoWe))) else $error("Start issued together with HI/LO write");

  // Issue one operation (caller sits 1 time unit after a rising edge); returns 1 unit after Busy falls.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int busy_n, output int done_early);
    Start = 1'b1; Op = op; OpA = a; OpB = b;
    @(posedge clk); #1;
    Start = 1'b0;
    busy_n = Busy ? 1 : 0;
    done_early = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!Busy) break;
      busy_n++;
      if (Done) done_early++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; Start = 0; Op = 0; OpA = 0; OpB = 0;
    HiWe = 0; LoWe = 0; WData = 0; ReadReq = 0; Abort = 0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({Hi, Lo} !== 64'h0) begin bad++; $display("FAIL reset_hilo: got %h want 0", {Hi, Lo}); end
    total++;
    if ({Busy, Stall, Done, DivZero} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {Busy, Stall, Done, DivZero});
    end
  endtask

  task automatic test_mult();
    int n, early;
    do_op(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, n, early);
    total++;
    if (n !== 33) begin bad++; $display("FAIL mult_busy_cycles: got %0d want 33", n); end
    total++;
    if (early !== 0) begin bad++; $display("FAIL mult_done_early: got %0d want 0", early); end
    total++;
    if ({Done, DivZero} !== 2'b10) begin bad++; $display("FAIL mult_done: got %b want 10", {Done, DivZero}); end
    total++;
    if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      bad++; $display("FAIL mult_neg: got %h want ffffffff_fffffffa", {Hi, Lo});
    end
    @(posedge clk); #1;
    total++;
    if (Done !== 1'b0) begin bad++; $display("FAIL mult_done_pulse: got %b want 0", Done); end
    do_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, n, early);
    total++;
    if ({Hi, Lo} !== 64'h4000_0000_0000_0000) begin
      bad++; $display("FAIL mult_minint_sq: got %h want 40000000_00000000", {Hi, Lo});
    end
  endtask

  task automatic test_multu_divu();
    int n, early;
    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, early);
    total++;
    if ({Hi, Lo} !== 64'hFFFF_FFFE_0000_0001) begin
      bad++; $display("FAIL multu_max: got %h want fffffffe_00000001", {Hi, Lo});
    end
    do_op(OP_DIVU, 32'd100, 32'd7, n, early);
    total++;
    if ({Hi, Lo} !== {32'd2, 32'd14}) begin bad++; $display("FAIL divu_100_7: got %h want 00000002_0000000e", {Hi, Lo}); end
    total++;
    if (n !== 33) begin bad++; $display("FAIL divu_busy_cycles: got %0d want 33", n); end
  endtask

  task automatic test_div();
    int n, early;
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, n, early);
    total++;
    if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      bad++; $display("FAIL div_m7_2: got %h want ffffffff_fffffffd", {Hi, Lo});
    end
    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n, early);
    total++;
    if ({Hi, Lo} !== 64'h0000_0000_8000_0000) begin
      bad++; $display("FAIL div_overflow: got %h want 00000000_80000000", {Hi, Lo});
    end
    do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, n, early);
    total++;
    if ({Hi, Lo} !== 64'h0000_0001_FFFF_FFFD) begin
      bad++; $display("FAIL div_7_m2: got %h want 00000001_fffffffd", {Hi, Lo});
    end
  endtask

  task automatic test_divzero();
    int n, early;
    do_op(OP_DIVU, 32'h0000_1234, 32'd0, n, early);
    total++;
    if ({Done, DivZero} !== 2'b11) begin bad++; $display("FAIL divu_zero_flags: got %b want 11", {Done, DivZero}); end
    total++;
    if ({Hi, Lo} !== 64'h0000_1234_FFFF_FFFF) begin
      bad++; $display("FAIL divu_zero: got %h want 00001234_ffffffff", {Hi, Lo});
    end
    total++;
    if (n !== 33) begin bad++; $display("FAIL divzero_busy_cycles: got %0d want 33", n); end
    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, n, early);
    total++;
    if ({Hi, Lo, DivZero} !== {64'hFFFF_FFF9_FFFF_FFFF, 1'b1}) begin
      bad++; $display("FAIL div_zero_signed: got %h/%b want fffffff9_ffffffff/1", {Hi, Lo}, DivZero);
    end
  endtask

  task automatic test_stall_mthi();
    int stall_n, miss;
    Start = 1'b1; Op = OP_MULTU; OpA = 32'd3; OpB = 32'd5;
    @(posedge clk); #1;
    Start = 1'b0;
    #1;
    total++;
    if (Stall !== 1'b0) begin bad++; $display("FAIL stall_no_req: got %b want 0", Stall); end
    repeat (4) @(posedge clk);
    #1 ReadReq = 1'b1;
    #1;
    stall_n = (Stall === 1'b1) ? 1 : 0;
    miss = (Stall === 1'b1) ? 0 : 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!Busy) break;
      if (Stall === 1'b1) stall_n++; else miss++;
    end
    total++;
    if (stall_n !== 29 || miss !== 0) begin
      bad++; $display("FAIL stall_cycles: got %0d (missed %0d) want 29 (missed 0)", stall_n, miss);
    end
    total++;
    if ({Stall, Done} !== 2'b01) begin bad++; $display("FAIL stall_release: got %b want 01", {Stall, Done}); end
    total++;
    if ({Hi, Lo} !== 64'h0000_0000_0000_000F) begin
      bad++; $display("FAIL mflo_after_busy: got %h want 00000000_0000000f", {Hi, Lo});
    end
    ReadReq = 1'b0;
    HiWe = 1'b1; WData = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    HiWe = 1'b0;
    total++;
    if ({Hi, Lo} !== 64'hA5A5_A5A5_0000_000F) begin
      bad++; $display("FAIL mthi_idle: got %h want a5a5a5a5_0000000f", {Hi, Lo});
    end
  endtask

  task automatic test_back_to_back();
    int n, early;
    do_op(OP_DIVU, 32'd100, 32'd7, n, early);
    do_op(OP_MULT, 32'd7, 32'hFFFF_FFFD, n, early);
    total++;
    if ({Hi, Lo, n} !== {64'hFFFF_FFFF_FFFF_FFEB, 32'd33}) begin
      bad++; $display("FAIL back_to_back: got %h n=%0d want ffffffff_ffffffeb n=33", {Hi, Lo}, n);
    end
  endtask

  task automatic test_abort();
    int done_n, busy_n;
    HiWe = 1'b1; LoWe = 1'b1; WData = 32'h5A5A_0000;
    @(posedge clk); #1;
    HiWe = 1'b0; LoWe = 1'b0;
    total++;
    if ({Hi, Lo} !== 64'h5A5A_0000_5A5A_0000) begin
      bad++; $display("FAIL mthi_mtlo_both: got %h want 5a5a0000_5a5a0000", {Hi, Lo});
    end
    Start = 1'b1; Op = OP_MULTU; OpA = 32'd9; OpB = 32'd9;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++;
    if ({Busy, Hi, Lo} !== {1'b1, 64'h5A5A_0000_5A5A_0000}) begin
      bad++; $display("FAIL run_hold: got %b/%h want 1/5a5a0000_5a5a0000", Busy, {Hi, Lo});
    end
    Abort = 1'b1;
    @(posedge clk); #1;
    Abort = 1'b0;
    total++;
    if ({Busy, Done} !== 2'b00) begin bad++; $display("FAIL abort_busy: got %b want 00", {Busy, Done}); end
    done_n = 0; busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (Done) done_n++;
      if (Busy) busy_n++;
    end
    total++;
    if (done_n !== 0 || busy_n !== 0 || {Hi, Lo} !== 64'h5A5A_0000_5A5A_0000) begin
      bad++; $display("FAIL abort_quiet: got done=%0d busy=%0d hilo=%h want 0 0 5a5a0000_5a5a0000", done_n, busy_n, {Hi, Lo});
    end
    Start = 1'b1; Abort = 1'b1; Op = OP_MULT;
    @(posedge clk); #1;
    Start = 1'b0; Abort = 1'b0;
    total++;
    if (Busy !== 1'b0) begin bad++; $display("FAIL abort_with_start: got %b want 0", Busy); end
  endtask

  task automatic test_async_reset();
    Start = 1'b1; Op = OP_MULTU; OpA = 32'd11; OpB = 32'd13;
    @(posedge clk); #1;
    Start = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    total++;
    if ({Hi, Lo, Busy} !== 65'h0) begin bad++; $display("FAIL async_reset: got %h/%b want 0/0", {Hi, Lo}, Busy); end
    #2 reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      total++;
      if ({Busy, Done} !== 2'b00) begin bad++; $display("FAIL post_reset_idle: got %b want 00", {Busy, Done}); break; end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu_divu();
    test_div();
    test_divzero();
    test_stall_mthi();
    test_back_to_back();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit with its own HI/LO registers for the pipelined MIPS core. Executes MULT, MULTU, DIV, DIVU, MTHI, MTLO and serves MFHI/MFLO.
- Sits beside the EX-stage ALU and is started by the EX stage.
- Sequences a 32-iteration shift-add or restoring-divide datapath.
- Raises a stall request to the hazard logic whenever the pipeline touches HI/LO while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; rising-edge.
- reset  input  1  asynchronous, active-high reset.
- Start  input  1  EX-stage MULT/MULTU/DIV/DIVU issue, one-cycle qualified pulse.
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with Start.
- OpA  input  WIDTH  rs value: multiplicand or dividend.
- OpB  input  WIDTH  rt value: multiplier or divisor.
- HiWe  input  1  MTHI in EX.
- LoWe  input  1  MTLO in EX.
- WData  input  WIDTH  data for MTHI/MTLO.
- ReadReq  input  1  MFHI/MFLO in EX.
- Abort  input  1  pipeline flush (IRQ or exception); cancels an in-flight operation.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.
- Busy  output  1  operation in flight.
- Stall  output  1  freeze IF/ID/EX, bubble MEM.
- Done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- DivZero  output  1  pulses with Done when a division had OpB==0.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). Reset forces state IDLE and Hi=Lo=0, Busy=0, Stall=0, Done=0, DivZero=0, counter=0. Reset mid-operation discards the operation.
- States: IDLE, RUN, FIX.
  - IDLE -> RUN on Start && !Abort. Latch Op, the sign flags and |OpA|, |OpB| (magnitudes only for signed ops), and clear the partial remainder/product. Counter=0.
  - RUN performs one iteration per cycle:
    - Multiply: shift-add one multiplier bit into the 2*WIDTH accumulator.
    - Divide: restoring shift-subtract, one quotient bit.
  - Counter increments each RUN cycle. At counter==WIDTH-1, go to FIX.
  - FIX (one cycle): apply signs, write Hi/Lo, pulse Done, go to IDLE.
- Latency: Start sampled at edge E0 -> Busy=1 from E0 through E33 (33 cycles). Hi/Lo and Done update at E33, and Busy falls at E33.
- Sign rules in FIX:
  - Product is negated when the operand signs differ (signed MULT only). Hi = upper WIDTH bits, Lo = lower.
  - Quotient -> Lo, remainder -> Hi. For DIV, the quotient is negated if the signs differ, and the remainder takes the dividend's sign.
  - Unsigned ops use raw values with no fix-up.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0. No trap.
- Divide by zero: full latency still taken. Result Hi=OpA (original, unsigned view), Lo=0xFFFFFFFF, for both DIV and DIVU. DivZero pulses with Done.
- Stall = Busy && (Start || ReadReq || HiWe || LoWe). Combinational; asserted in the same cycle as the conflicting EX request.
- Hi/Lo outputs hold their old values throughout RUN. An MFHI/MFLO issued in the cycle after Busy falls reads the new values.
- MTHI/MTLO with Busy=0: Hi or Lo <= WData at the next edge. HiWe and LoWe together write both.
- Start together with HiWe/LoWe in IDLE: Start wins and the writes are ignored. The pipeline never issues this combination; the bench flags it with an assertion.
- Abort:
  - In RUN or FIX: next state IDLE, Hi/Lo unchanged, no Done, Busy=0 after the edge.
  - Abort together with Start in IDLE: Start ignored.
  - Abort has priority over FIX completion.
- Start while Busy is never accepted. It is held via Stall and re-presented by the pipeline.

Test Plan:
1. MULT 0xFFFFFFFE (-2) x 0x00000003 -> after 33 cycles Done, Hi=0xFFFFFFFF, Lo=0xFFFFFFFA. Busy high exactly 33 cycles.
2. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001. DIVU 100/7 -> Lo=14, Hi=2.
3. DIV -7 (0xFFFFFFF9) / 2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1). DIV 0x80000000 / -1 -> Lo=0x80000000, Hi=0.
4. DIVU 0x1234 / 0 -> Hi=0x1234, Lo=0xFFFFFFFF, DivZero and Done pulse together.
5. ReadReq asserted 5 cycles after Start -> Stall=1 in that cycle and every cycle until Busy falls. The MFLO issued the cycle after that reads the new Lo. MTHI 0xA5A5A5A5 while idle -> Hi=0xA5A5A5A5 next cycle.
6. Abort at RUN cycle 10 -> Busy=0 next cycle, no Done, Hi/Lo keep prior values. Asynchronous reset mid-RUN -> immediate Hi=Lo=0, Busy=0.
